// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP engine and its histogram consumer:
// frame geometry defaults, histogram FSM states and the border test.
package lbp_pkg;

  localparam int LBP_IMG_W  = 128;
  localparam int LBP_ADDR_W = 14;
  localparam int LBP_CNT_W  = 15;
  localparam int HIST_BINS  = 256;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } hist_state_t;

  // A pixel is on the border when it sits in the first/last row or column.
  function automatic logic is_border(input int unsigned row,
                                     input int unsigned col,
                                     input int unsigned last);
    return (row == 0) || (col == 0) || (row == last) || (col == last);
  endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// 256-entry bank of saturating bin counters: one increment port and one
// combinational read port, all counters cleared by the async reset.
module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = LBP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [7:0]       inc_idx,
  input  logic [7:0]       rd_idx,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_arr [HIST_BINS];

  genvar gi;
  generate
    for (gi = 0; gi < HIST_BINS; gi++) begin : g_bin
      logic [CNT_W-1:0] cnt_reg;
      logic             hit;

      assign hit = inc_en && (inc_idx == 8'(gi));

      // Each bin owns its own adder, so back-to-back hits never stall.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (hit && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  assign rd_cnt = cnt_arr[rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// Histogram of LBP codes for one frame: snoops the LBP write port while
// accumulating, then drains the 256 bins in order over ready/valid.
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int IMG_W          = LBP_IMG_W,
  parameter int ADDR_W         = LBP_ADDR_W,
  parameter int CNT_W          = LBP_CNT_W,
  parameter int EXCLUDE_BORDER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [7:0]        lbp_data,
  input  logic              finish,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [7:0]        hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_done,
  output logic              drop_err
);

  localparam int COL_W = $clog2(IMG_W);

  hist_state_t state_reg, state_next;
  logic [7:0]  ptr_reg, ptr_next;
  logic        hist_valid_reg, hist_done_reg, drop_err_reg;
  logic        border, inc_en, accept;

  assign border = is_border(32'(lbp_addr[ADDR_W-1:COL_W]),
                            32'(lbp_addr[COL_W-1:0]),
                            32'(IMG_W - 1));
  assign accept = hist_valid_reg && hist_ready;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    inc_en     = 1'b0;
    case (state_reg)
      ACC: begin
        // A beat coinciding with finish still lands in its bin.
        inc_en = lbp_valid && !((EXCLUDE_BORDER != 0) && border);
        if (finish) begin
          state_next = DUMP;
          ptr_next   = 8'd0;
        end
      end
      DUMP: begin
        if (accept) begin
          if (ptr_reg == 8'hFF) begin
            state_next = DONE;
          end else begin
            ptr_next = ptr_reg + 8'd1;
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ACC;
      ptr_reg        <= 8'd0;
      hist_valid_reg <= 1'b0;
      hist_done_reg  <= 1'b0;
      drop_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      hist_valid_reg <= (state_next == DUMP);
      hist_done_reg  <= hist_done_reg || (state_next == DONE);
      drop_err_reg   <= drop_err_reg || (lbp_valid && (state_reg != ACC));
    end
  end

  lbp_hist_bank #(
    .CNT_W (CNT_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (reset),
    .inc_en  (inc_en),
    .inc_idx (lbp_data),
    .rd_idx  (ptr_reg),
    .rd_cnt  (hist_count)
  );

  assign hist_valid = hist_valid_reg;
  assign hist_bin   = ptr_reg;
  assign hist_done  = hist_done_reg;
  assign drop_err   = drop_err_reg;

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream consumer of the LBP engine's output stream. It snoops the `lbp_valid`/`lbp_addr`/`lbp_data` write port that feeds LBP memory and accumulates a 256-bin histogram of LBP codes for one 128x128 frame. When the engine raises `finish`, it drains the bins in order over a ready/valid port. The histogram is the texture feature vector passed to later classification stages.

## Interface
- `IMG_W`, 128: image width and height in pixels; address = row*IMG_W + col.
- `ADDR_W`, 14: width of `lbp_addr`.
- `CNT_W`, 15: width of each bin counter; must hold IMG_W*IMG_W.
- `EXCLUDE_BORDER`, 1: 1 = discard beats whose pixel is in row 0, row IMG_W-1, col 0 or col IMG_W-1; 0 = count every beat.
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-low; 0 = reset asserted.
- `lbp_valid` in 1: LBP write strobe; one pixel per cycle when high.
- `lbp_addr` in ADDR_W: pixel address of the beat.
- `lbp_data` in 8: LBP code, which is the bin index.
- `finish` in 1: level from the LBP engine; frame complete.
- `hist_valid` out 1: a histogram bin is presented.
- `hist_ready` in 1: downstream accepts the bin.
- `hist_bin` out 8: bin index, 0..255.
- `hist_count` out CNT_W: count for `hist_bin`.
- `hist_done` out 1: all 256 bins accepted; sticky until reset.
- `drop_err` out 1: sticky; a beat arrived while not accumulating.

## Operation
- **States:** ACC (reset state), DUMP, DONE.
- **ACC:**
  - A beat with `lbp_valid`=1 increments `bins[lbp_data]` by 1, unless it is a border beat with EXCLUDE_BORDER=1.
  - Counters saturate at 2^CNT_W-1.
  - Back-to-back beats to the same bin each count. The increment is single-cycle and there is no read-modify-write gap.
- **ACC -> DUMP:** on a posedge with `finish`=1.
  - A beat in that same cycle is still counted.
  - `ptr` is cleared to 0.
- **DUMP:**
  - `hist_valid`=1, `hist_bin`=ptr, `hist_count`=bins[ptr].
  - On `hist_valid && hist_ready`, ptr increments.
  - Acceptance at ptr=255 moves to DONE.
  - While `hist_ready`=0, the outputs hold stable.
- **DONE:** `hist_valid`=0 and `hist_done`=1; the block stays here until reset. `finish` is ignored in DUMP and DONE.
- **Beats outside ACC:** any `lbp_valid`=1 in DUMP or DONE sets `drop_err`; bins are unchanged.
- **Border test:**
  - row = lbp_addr[ADDR_W-1:7] and col = lbp_addr[6:0], for IMG_W=128.
  - A beat is a border beat when row or col is 0 or 127.
- **Reset:**
  - Asserting reset at any time, including mid-DUMP, clears all bins, ptr, the state (to ACC) and all outputs asynchronously.
  - Reset values: `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `hist_done`=0, `drop_err`=0.

## Timing
- Accumulation latency: a beat sampled at edge t is visible in `bins` after edge t.
- If `finish` is sampled at edge t, `hist_valid` rises after edge t and `hist_bin`=0.
- Full drain with `hist_ready` held at 1 takes 256 cycles. `hist_done` rises after the edge that accepts bin 255.
- `hist_valid`, `hist_bin` and `hist_done` are registered. `hist_count` is a mux output from the registered ptr and bin array, with no input-to-output combinational path.
- `hist_valid` never drops in DUMP without acceptance (standard valid/ready: data held until accepted).

## Structure
- **Shared package `lbp_pkg`:** IMG_W, ADDR_W, CNT_W defaults, a `hist_state_t` enum (ACC, DUMP, DONE), and a border-test function. This package is shared with the LBP engine.
- **Sub-module `lbp_hist_bank`:** 256 x CNT_W counter array with async clear, one saturating increment port (`inc_en`, `inc_idx`) and one combinational read port (`rd_idx`, `rd_cnt`).
- **Top `lbp_hist`:** FSM, border filter, ptr and sticky flags.

## Test plan
- **Empty frame:** reset, no beats, `finish`=1 -> 256 handshakes, all `hist_count`=0, then `hist_done`=1.
- **Full frame, border excluded:** all 16384 addresses with `lbp_data`=0x5A, EXCLUDE_BORDER=1 -> bin 0x5A=15876 and all other bins 0.
- **Full frame, border counted:** EXCLUDE_BORDER=0 -> bin 0x5A=16384.
- **Back-to-back and coincident finish:** beats to bin 0x03 on 5 consecutive cycles, with the last beat in the same cycle as `finish` rising -> bin 3=5, and the DUMP output starts the next cycle.
- **Backpressure:** `hist_ready` toggles 1,0,0,1 during DUMP -> `hist_bin`/`hist_count` held while ready is 0, no bin skipped or repeated, 256 acceptances total.
- **Drop and reset mid-DUMP:** `lbp_valid` pulse during DUMP -> `drop_err`=1, counts unchanged; reset asserted mid-DUMP -> all outputs 0, state ACC, a new frame accumulates from zero.
